// File: rtl/vga_v_timing.sv
// Vertical timing stage: line counter plus registered h/v sync, blank and frame-start decode.
// Latency: every output is the decode of hcount_in and the line count from one pclk earlier.
// Backpressure: none; free-running raster pipeline, consumes one hcount_in every pclk.
module vga_v_timing #(
  parameter int unsigned H_VISIBLE    = 800,
  parameter int unsigned H_SYNC_START = 840,
  parameter int unsigned H_SYNC_LEN   = 128,
  parameter int unsigned H_TOTAL      = 1056,
  parameter int unsigned V_VISIBLE    = 600,
  parameter int unsigned V_SYNC_START = 601,
  parameter int unsigned V_SYNC_LEN   = 4,
  parameter int unsigned V_TOTAL      = 628
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic        end_of_line,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        frame_start
);

  // All compares are done on unsigned 11-bit values, matching the count width.
  localparam logic [10:0] H_VIS_W   = 11'(H_VISIBLE);
  localparam logic [10:0] H_SS_W    = 11'(H_SYNC_START);
  localparam logic [10:0] H_SE_W    = 11'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [10:0] H_LAST_W  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_VIS_W   = 11'(V_VISIBLE);
  localparam logic [10:0] V_SS_W    = 11'(V_SYNC_START);
  localparam logic [10:0] V_SE_W    = 11'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [10:0] V_LAST_W  = 11'(V_TOTAL - 1);

  logic        eol_q;
  logic [10:0] v_cnt;
  logic        line_adv;
  logic        hsync_d;
  logic        hblank_d;
  logic        vsync_d;
  logic        vblank_d;
  logic        fs_d;

  // Delay the early end-of-line strobe so it coincides with the last pixel of the line.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      eol_q <= 1'b0;
    end else begin
      eol_q <= end_of_line;
    end
  end

  // Advance only when the strobe and the last-pixel count agree; a stuck or stray strobe
  // therefore yields at most one advance per line.
  always_comb begin
    line_adv = eol_q && (hcount_in == H_LAST_W);
  end

  // Line counter steps on the edge where upstream hcount wraps to 0; any out-of-range
  // value falls back to line 0 on the next advance.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      v_cnt <= 11'd0;
    end else if (line_adv) begin
      if (v_cnt >= V_LAST_W) begin
        v_cnt <= 11'd0;
      end else begin
        v_cnt <= v_cnt + 11'd1;
      end
    end
  end

  // Decode the raster phase from the consistent (hcount_in, v_cnt) pair.
  always_comb begin
    hsync_d  = (hcount_in >= H_SS_W) && (hcount_in < H_SE_W);
    hblank_d = (hcount_in >= H_VIS_W);
    vsync_d  = (v_cnt >= V_SS_W) && (v_cnt < V_SE_W);
    vblank_d = (v_cnt >= V_VIS_W);
    fs_d     = (hcount_in == 11'd0) && (v_cnt == 11'd0);
  end

  // Register counts and decodes together so everything leaves the block aligned.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= hcount_in;
      vcount      <= v_cnt;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      hblank      <= hblank_d;
      vblank      <= vblank_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_vga_v_timing.sv
module tb_vga_v_timing;

  localparam int HT = 1056;
  localparam int VT = 628;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = 11'd0;
  logic        end_of_line = 1'b0;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblank;
  logic        vblank;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  // Reference model state: current line number and last cycle's strobe.
  int exp_line = 0;
  bit prev_eol = 1'b0;

  // Statistics gathered from observed outputs.
  int fs_seen  = 0;
  int vs_lines = 0;
  int vb_lines = 0;
  int max_v    = 0;

  always #5 pclk = ~pclk;

  vga_v_timing dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .hcount_in   (hcount_in),
    .end_of_line (end_of_line),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .hblank      (hblank),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hcount"}, 32'(hcount), 32'd0);
    check({tag, "_vcount"}, 32'(vcount), 32'd0);
    check({tag, "_hsync"},  32'(hsync),  32'd0);
    check({tag, "_vsync"},  32'(vsync),  32'd0);
    check({tag, "_hblank"}, 32'(hblank), 32'd0);
    check({tag, "_vblank"}, 32'(vblank), 32'd0);
    check({tag, "_fs"},     32'(frame_start), 32'd0);
  endtask

  // Drive one pixel, check the registered outputs against the model, then advance the model.
  task automatic step(input int h, input bit e);
    hcount_in   = h[10:0];
    end_of_line = e;
    @(posedge pclk);
    #1;
    check("hcount", 32'(hcount), 32'(h));
    check("vcount", 32'(vcount), 32'(exp_line));
    check("hsync",  32'(hsync),  32'(h >= 840 && h < 968));
    check("hblank", 32'(hblank), 32'(h >= 800));
    check("vsync",  32'(vsync),  32'(exp_line >= 601 && exp_line <= 604));
    check("vblank", 32'(vblank), 32'(exp_line >= 600));
    check("frame_start", 32'(frame_start), 32'(h == 0 && exp_line == 0));
    if (frame_start === 1'b1) fs_seen++;
    if (h == 0 && vsync === 1'b1) vs_lines++;
    if (h == 0 && vblank === 1'b1) vb_lines++;
    if (int'(vcount) > max_v) max_v = int'(vcount);
    if (prev_eol && h == HT - 1) exp_line = (exp_line + 1) % VT;
    prev_eol = e;
  endtask

  // A shortened line: start pixel, strobe at HT-2, last pixel, advancing the line once.
  task automatic fast_line();
    step(0, 1'b0);
    step(HT - 2, 1'b1);
    step(HT - 1, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    check_all_zero("reset");

    // Release with hcount_in at 0: frame_start one cycle later
    hcount_in = 11'd0;
    rst_n = 1'b1;
    step(0, 1'b0);
    check("fs_after_reset", 32'(frame_start), 32'd1);

    // Two full lines from a real upstream counter, sweeping all h edges
    for (int l = 0; l < 2; l++) begin
      for (int h = 1; h < HT; h++) begin
        step(h, h == HT - 2);
        if (h == 839)  check("hsync_839", 32'(hsync), 32'd0);
        if (h == 840)  check("hsync_840", 32'(hsync), 32'd1);
        if (h == 967)  check("hsync_967", 32'(hsync), 32'd1);
        if (h == 968)  check("hsync_968", 32'(hsync), 32'd0);
        if (h == 799)  check("hblank_799", 32'(hblank), 32'd0);
        if (h == 800)  check("hblank_800", 32'(hblank), 32'd1);
        if (h == 1055) check("wrap_old_v", 32'(vcount), 32'(l));
      end
      step(0, 1'b0);
      check("wrap_new_v", 32'(vcount), 32'(l + 1));
      check("hblank_0", 32'(hblank), 32'd0);
    end

    // Spurious strobe away from the line end: no advance
    step(200, 1'b1);
    step(201, 1'b0);
    check("spurious_v", 32'(vcount), 32'd2);

    // Strobe stuck high for a whole line: exactly one advance
    for (int h = 202; h < HT; h++) step(h, 1'b1);
    for (int h = 0; h < 6; h++) step(h, 1'b1);
    check("stuck_eol_v", 32'(vcount), 32'd3);
    end_of_line = 1'b0;

    // Walk to line 300 and sit at hcount_in=500, then reset mid-frame
    while (exp_line != 300) fast_line();
    step(500, 1'b0);
    check("pre_reset_v", 32'(vcount), 32'd300);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset_async");
    hcount_in = 11'd0;
    repeat (2) @(posedge pclk);
    #1;
    check_all_zero("midreset_hold");
    exp_line = 0;
    prev_eol = 1'b0;
    fs_seen = 0;
    vs_lines = 0;
    vb_lines = 0;
    max_v = 0;
    rst_n = 1'b1;

    // Three frames from reset using shortened lines
    step(0, 1'b0);
    check("fs_after_midreset", 32'(frame_start), 32'd1);
    step(HT - 2, 1'b1);
    step(HT - 1, 1'b0);
    for (int l = 1; l < 3 * VT; l++) fast_line();
    check("frame_last_v", 32'(vcount), 32'(VT - 1));
    check("frames_fs_count", 32'(fs_seen), 32'd3);
    check("frames_vsync_lines", 32'(vs_lines), 32'd12);
    check("frames_vblank_lines", 32'(vb_lines), 32'd84);
    check("frames_max_v", 32'(max_v), 32'(VT - 1));
    step(0, 1'b0);
    check("frame_wrap_v", 32'(vcount), 32'd0);
    check("frame_wrap_fs", 32'(frame_start), 32'd1);

    // Randomized hcount_in / strobe mix against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      int h;
      r = int'($urandom_range(0, 9));
      if (r < 3)      h = HT - 2;
      else if (r < 6) h = HT - 1;
      else if (r < 7) h = 0;
      else if (r < 9) h = int'($urandom_range(0, HT - 1));
      else            h = int'($urandom_range(0, 2047));
      step(h, ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
